// File: rtl/pin_entry_ctrl.sv
// PS/2 set-2 scan-code sequencer feeding an 8-digit BCD PIN/amount entry buffer with a valid/ready commit port.
// Optional build macro NUMPAD_EN: numeric keypad make codes also enter digits.
module pin_entry_ctrl #(
  parameter int MAX_DIGITS = 8,
  parameter int MIN_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        code_valid,
  input  logic [7:0]  code,
  input  logic        commit_ready,
  output logic [31:0] disp_word,
  output logic [7:0]  disp_mask,
  output logic [3:0]  digit_count,
  output logic        commit_valid,
  output logic [31:0] commit_data,
  output logic [3:0]  commit_len,
  output logic        err_pulse
);

  typedef enum logic [1:0] {NORMAL, GOT_E0, GOT_F0} pfx_t;
  typedef enum logic [2:0] {ACT_NONE, ACT_DIGIT, ACT_ENTER, ACT_BKSP, ACT_ESC} act_t;

  localparam logic [31:0] BUF_MASK = (MAX_DIGITS >= 8) ? 32'hFFFF_FFFF :
                                     32'((64'd1 << (4 * MAX_DIGITS)) - 64'd1);

  // Returns {hit, digit}; hit=0 when the byte is not a digit make code.
  function automatic logic [4:0] decode_digit(input logic [7:0] c);
    logic [4:0] r;
    case (c)
      8'h45: r = {1'b1, 4'd0};
      8'h16: r = {1'b1, 4'd1};
      8'h1E: r = {1'b1, 4'd2};
      8'h26: r = {1'b1, 4'd3};
      8'h25: r = {1'b1, 4'd4};
      8'h2E: r = {1'b1, 4'd5};
      8'h36: r = {1'b1, 4'd6};
      8'h3D: r = {1'b1, 4'd7};
      8'h3E: r = {1'b1, 4'd8};
      8'h46: r = {1'b1, 4'd9};
`ifdef NUMPAD_EN
      8'h70: r = {1'b1, 4'd0};
      8'h69: r = {1'b1, 4'd1};
      8'h72: r = {1'b1, 4'd2};
      8'h7A: r = {1'b1, 4'd3};
      8'h6B: r = {1'b1, 4'd4};
      8'h73: r = {1'b1, 4'd5};
      8'h74: r = {1'b1, 4'd6};
      8'h6C: r = {1'b1, 4'd7};
      8'h75: r = {1'b1, 4'd8};
      8'h7D: r = {1'b1, 4'd9};
`endif
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] mask_of(input logic [3:0] cnt);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = (4'(i) < cnt);
    return m;
  endfunction

  pfx_t        pfx_q;
  act_t        act;
  logic [3:0]  dig;
  logic [4:0]  dd;
  logic [31:0] entry_q, entry_d, cdata_d;
  logic [3:0]  cnt_d, clen_d;
  logic        cv_d, err_d;

  // Stage 0: decode the incoming byte against the current prefix state
  always_comb begin
    act = ACT_NONE;
    dig = 4'd0;
    dd  = decode_digit(code);
    if (code_valid) begin
      case (pfx_q)
        NORMAL: begin
          if (dd[4]) begin
            act = ACT_DIGIT;
            dig = dd[3:0];
          end else begin
            case (code)
              8'h5A:   act = ACT_ENTER;
              8'h66:   act = ACT_BKSP;
              8'h76:   act = ACT_ESC;
              default: act = ACT_NONE;
            endcase
          end
        end
        GOT_E0:  if (code == 8'h5A) act = ACT_ENTER;
        default: act = ACT_NONE;
      endcase
    end
  end

  // Acceptance clears the entry first; a same-cycle action then applies to the cleared state.
  always_comb begin
    entry_d = (commit_valid && commit_ready) ? 32'd0 : entry_q;
    cnt_d   = (commit_valid && commit_ready) ? 4'd0 : digit_count;
    cv_d    = commit_valid && !commit_ready;
    cdata_d = commit_data;
    clen_d  = commit_len;
    err_d   = 1'b0;
    if (!cv_d) begin
      case (act)
        ACT_DIGIT: begin
          if (cnt_d < 4'(MAX_DIGITS)) begin
            entry_d = {entry_d[27:0], dig} & BUF_MASK;
            cnt_d   = cnt_d + 4'd1;
          end else begin
            err_d = 1'b1;
          end
        end
        ACT_BKSP: begin
          if (cnt_d != 4'd0) begin
            entry_d = {4'h0, entry_d[31:4]};
            cnt_d   = cnt_d - 4'd1;
          end
        end
        ACT_ESC: begin
          entry_d = 32'd0;
          cnt_d   = 4'd0;
        end
        ACT_ENTER: begin
          if (cnt_d >= 4'(MIN_DIGITS)) begin
            cv_d    = 1'b1;
            cdata_d = entry_d;
            clen_d  = cnt_d;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage 1: registered state and outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pfx_q        <= NORMAL;
      entry_q      <= 32'd0;
      disp_word    <= 32'd0;
      disp_mask    <= 8'd0;
      digit_count  <= 4'd0;
      commit_valid <= 1'b0;
      commit_data  <= 32'd0;
      commit_len   <= 4'd0;
      err_pulse    <= 1'b0;
    end else begin
      if (code_valid) begin
        case (pfx_q)
          NORMAL:  pfx_q <= (code == 8'hF0) ? GOT_F0 : (code == 8'hE0) ? GOT_E0 : NORMAL;
          GOT_E0:  pfx_q <= (code == 8'hF0) ? GOT_F0 : NORMAL;
          default: pfx_q <= NORMAL;
        endcase
      end
      entry_q      <= entry_d;
      disp_word    <= entry_d;
      disp_mask    <= mask_of(cnt_d);
      digit_count  <= cnt_d;
      commit_valid <= cv_d;
      commit_data  <= cdata_d;
      commit_len   <= clen_d;
      err_pulse    <= err_d;
    end
  end

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Self-checking bench for pin_entry_ctrl: key-level reference model compared every cycle plus directed literal checks.
module tb_pin_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        code_valid = 1'b0;
  logic [7:0]  code = 8'h00;
  logic        commit_ready = 1'b0;
  logic [31:0] disp_word;
  logic [7:0]  disp_mask;
  logic [3:0]  digit_count;
  logic        commit_valid;
  logic [31:0] commit_data;
  logic [3:0]  commit_len;
  logic        err_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  pin_entry_ctrl dut (
    .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code(code),
    .commit_ready(commit_ready), .disp_word(disp_word), .disp_mask(disp_mask),
    .digit_count(digit_count), .commit_valid(commit_valid), .commit_data(commit_data),
    .commit_len(commit_len), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  logic [7:0] main_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] pad_codes[10]  = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

  // Reference model: digits kept as a list, oldest first.
  int          mq[$];
  bit          m_cv, m_err, f0s, e0s;
  logic [31:0] m_cdata;
  int          m_clen;

  function automatic int digit_of(input logic [7:0] b);
    for (int i = 0; i < 10; i++) if (main_codes[i] == b) return i;
`ifdef NUMPAD_EN
    for (int i = 0; i < 10; i++) if (pad_codes[i] == b) return i;
`endif
    return -1;
  endfunction

  function automatic logic [31:0] word_of_model();
    logic [31:0] w = 32'd0;
    foreach (mq[i]) w = (w << 4) | 32'(mq[i]);
    return w;
  endfunction

  always @(posedge clk) begin
    string act;
    int d;
    act = "none";
    d = -1;
    if (!rst_n) begin
      mq.delete(); m_cv = 0; m_err = 0; f0s = 0; e0s = 0; m_cdata = 0; m_clen = 0;
    end else begin
      m_err = 0;
      if (code_valid) begin
        if (f0s) begin
          f0s = 0;
        end else if (e0s) begin
          e0s = 0;
          if (code == 8'hF0) f0s = 1;
          else if (code == 8'h5A) act = "enter";
        end else if (code == 8'hF0) f0s = 1;
        else if (code == 8'hE0) e0s = 1;
        else begin
          d = digit_of(code);
          if (d >= 0) act = "digit";
          else if (code == 8'h5A) act = "enter";
          else if (code == 8'h66) act = "bksp";
          else if (code == 8'h76) act = "esc";
        end
      end
      if (m_cv && commit_ready) begin
        m_cv = 0;
        mq.delete();
      end
      if (!m_cv) begin
        if (act == "digit") begin
          if (mq.size() < 8) mq.push_back(d);
          else m_err = 1;
        end else if (act == "bksp") begin
          if (mq.size() > 0) void'(mq.pop_back());
        end else if (act == "esc") begin
          mq.delete();
        end else if (act == "enter") begin
          if (mq.size() >= 4) begin
            m_cv = 1; m_cdata = word_of_model(); m_clen = mq.size();
          end else m_err = 1;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act_v, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_disp_word", disp_word, word_of_model());
      check("m_disp_mask", 32'(disp_mask), (32'd1 << mq.size()) - 32'd1);
      check("m_digit_count", 32'(digit_count), 32'(mq.size()));
      check("m_commit_valid", 32'(commit_valid), 32'(m_cv));
      check("m_err_pulse", 32'(err_pulse), 32'(m_err));
      if (m_cv) begin
        check("m_commit_data", commit_data, m_cdata);
        check("m_commit_len", 32'(commit_len), 32'(m_clen));
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    code_valid = 1'b1;
    code = b;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic key(input int d);
    send(main_codes[d]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    @(posedge clk);
    @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_word", disp_word, 32'd0);
    check("rst_cv", 32'(commit_valid), 32'd0);
    rst_n = 1'b1;

    // Make/break pairs
    send(8'h16); send(8'hF0); send(8'h16); send(8'h1E); send(8'hF0); send(8'h1E);
    check("t1_count", 32'(digit_count), 32'd2);
    check("t1_word", disp_word, 32'h0000_0012);
    check("t1_mask", 32'(disp_mask), 32'h03);
    send(8'h76);

    // Commit and hold
    key(1); key(2); key(3); key(4); send(8'h5A);
    idle(5);
    check("t2_cv", 32'(commit_valid), 32'd1);
    check("t2_data", commit_data, 32'h0000_1234);
    check("t2_len", 32'(commit_len), 32'd4);
    send(8'hF0); send(8'h5A); key(9); send(8'h76);
    check("t2_hold_data", commit_data, 32'h0000_1234);
    check("t2_hold_word", disp_word, 32'h0000_1234);
    commit_ready = 1'b1;
    @(negedge clk);
    commit_ready = 1'b0;
    check("t2_acc_count", 32'(digit_count), 32'd0);
    check("t2_acc_cv", 32'(commit_valid), 32'd0);

    // Acceptance coinciding with a digit
    key(6); key(7); key(8); key(9); send(8'h5A);
    commit_ready = 1'b1;
    code_valid = 1'b1;
    code = 8'h2E;
    @(negedge clk);
    commit_ready = 1'b0;
    code_valid = 1'b0;
    check("t2b_count", 32'(digit_count), 32'd1);
    check("t2b_word", disp_word, 32'h0000_0005);
    send(8'h76);

    // Enter below minimum
    key(1); key(2); key(3); send(8'h5A);
    check("t3_err", 32'(err_pulse), 32'd1);
    check("t3_cv", 32'(commit_valid), 32'd0);
    check("t3_word", disp_word, 32'h0000_0123);
    idle(1);
    check("t3_err_gone", 32'(err_pulse), 32'd0);
    send(8'h76);

    // Overflow, backspace, escape
    for (int i = 1; i <= 8; i++) key(i);
    key(9);
    check("t4_err", 32'(err_pulse), 32'd1);
    check("t4_word", disp_word, 32'h1234_5678);
    check("t4_mask", 32'(disp_mask), 32'hFF);
    send(8'h66);
    check("t4_bs_word", disp_word, 32'h0123_4567);
    check("t4_bs_count", 32'(digit_count), 32'd7);
    send(8'h76);
    check("t4_esc_word", disp_word, 32'd0);
    check("t4_esc_count", 32'(digit_count), 32'd0);

    // Empty backspace and E0 F0 5A
    send(8'h66);
    check("t5_bs_err", 32'(err_pulse), 32'd0);
    check("t5_bs_count", 32'(digit_count), 32'd0);
    send(8'hE0); send(8'hF0); send(8'h5A);
    check("t5_cv", 32'(commit_valid), 32'd0);
    check("t5_err", 32'(err_pulse), 32'd0);
    key(7);
    check("t5_word", disp_word, 32'h0000_0007);
    send(8'h76);

    // Keypad entry with keypad Enter
    send(8'h69); send(8'h72); send(8'h7A); send(8'h6B); send(8'hE0); send(8'h5A);
`ifdef NUMPAD_EN
    check("t6_cv", 32'(commit_valid), 32'd1);
    check("t6_data", commit_data, 32'h0000_1234);
    commit_ready = 1'b1;
    @(negedge clk);
    commit_ready = 1'b0;
`else
    check("t6_count", 32'(digit_count), 32'd0);
    check("t6_err", 32'(err_pulse), 32'd1);
`endif

    // Reset while a commit is pending
    key(4); key(3); key(2); key(1); send(8'h5A);
    check("t7_cv", 32'(commit_valid), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t7_rst_cv", 32'(commit_valid), 32'd0);
    check("t7_rst_count", 32'(digit_count), 32'd0);
    key(2);
    check("t7_word", disp_word, 32'h0000_0002);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pin_entry_ctrl.md
Name: pin_entry_ctrl

Overview:
Sequences the PS/2 scan-code stream into a PIN/amount entry buffer for the crypto ATM front panel. Consumes one-cycle code strobes from the keyboard receiver path, and does the following:
- strips set-2 break (F0) and extended (E0) prefixes;
- edits an 8-digit BCD buffer on digit, backspace and escape;
- drives the 7-segment display word;
- hands committed entries to the downstream transaction logic via a valid/ready handshake.

Parameters:
MAX_DIGITS, 8, buffer capacity in digits (legal 1..8)
MIN_DIGITS, 4, minimum digit count for Enter to commit (legal 1..MAX_DIGITS)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low
code_valid  input  1  one-cycle strobe: code holds a new scan-code byte
code  input  8  PS/2 set-2 scan-code byte
commit_ready  input  1  downstream accepts commit this cycle
disp_word  output  32  8 BCD nibbles; nibble 0 = most recently entered digit
disp_mask  output  8  bit i = 1 when nibble i holds an entered digit (display blanks others)
digit_count  output  4  digits currently held, 0..MAX_DIGITS
commit_valid  output  1  committed entry pending
commit_data  output  32  frozen buffer contents while commit_valid
commit_len  output  4  frozen digit count while commit_valid
err_pulse  output  1  one-cycle pulse on rejected action

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clock edge): all outputs 0; buffer 0; prefix FSM = NORMAL; commit pending cleared. Reset mid-commit drops the pending entry.
- Prefix FSM. It runs every cycle code_valid=1, independent of commit state.
  - NORMAL: F0 -> GOT_F0; E0 -> GOT_E0; otherwise decode as a make code -> NORMAL.
  - GOT_E0: F0 -> GOT_F0; 5A -> Enter action; any other -> ignored. Exits to NORMAL except on F0.
  - GOT_F0: any byte discarded -> NORMAL (release codes never act).
- Make decode (NORMAL):
  - digits 45,16,1E,26,25,2E,36,3D,3E,46 = 0..9
  - 5A = Enter; 66 = Backspace; 76 = Escape
  - all others ignored
  - typematic repeats act as fresh presses
- Actions (only when no commit pending; while pending, actions are dropped silently with no err_pulse):
  - Digit d, count<MAX_DIGITS: buf <= {buf[27:0],d}; count+1.
  - Digit at count==MAX_DIGITS: dropped; err_pulse.
  - Backspace: buf <= {4'h0,buf[31:4]}; count-1. At count 0: no-op, no error.
  - Escape: buf <= 0; count <= 0.
  - Enter, count>=MIN_DIGITS: commit_valid <= 1; commit_data/commit_len latch buf/count.
  - Enter, count<MIN_DIGITS: err_pulse; buffer unchanged.
- Latency: action from a code at edge n is visible on disp_word/disp_mask/digit_count/commit_valid/err_pulse after edge n (one cycle).
- Handshake:
  - commit_valid, commit_data and commit_len are held stable until a cycle with commit_valid && commit_ready.
  - At that edge: commit_valid <= 0; buffer and count clear to 0.
  - A code arriving in the same cycle as acceptance is processed as if no commit were pending, applied after the clear. Example: digit 5 in the accept cycle yields count 1, nibble0 = 5.
- Display: disp_word = buf; disp_mask bit i = (i < count).
- Bits above MAX_DIGITS*4 stay 0.

Optional Feature:
NUMPAD_EN.
- Defined: numeric keypad make codes 70,69,72,7A,6B,73,74,6C,75,7D decode as digits 0..9, and E0 5A (keypad Enter) acts as Enter.
- Undefined: keypad digit codes are ignored; E0 5A is still Enter.

Test Plan:
- Reset, then strobes 16,F0,16,1E,F0,1E -> digit_count=2, disp_word=0x00000012, disp_mask=0x03, err_pulse never high.
- Enter digits 1,2,3,4 then 5A with commit_ready=0 for 5 cycles -> commit_valid=1 held, commit_data=0x00001234, commit_len=4. Then F0,5A during hold -> no change. Then commit_ready=1 -> count=0 next cycle.
- Digits 1,2,3 then 5A (MIN=4) -> err_pulse one cycle, commit_valid=0, disp_word=0x00000123.
- Nine digits 1..9 -> 9th raises err_pulse, disp_word=0x12345678. Then 66 -> 0x01234567, count=7. Then 76 -> 0, count=0.
- 66 at count 0 -> no change, no err_pulse. Then E0,F0,5A -> no commit, FSM back to NORMAL. Then digit 7 -> 0x00000007.
- NUMPAD_EN: 69,72,7A,6B,E0,5A -> commit_data=0x00001234. Without the macro: count=0, err_pulse on the Enter.
